// File: rtl/imem_ctrl_pkg.sv
// Shared constants for the instruction-memory controller: sizes, NOP word
// and the controller state encoding.
package imem_ctrl_pkg;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/imem_ctrl_word_packer.sv
// Little-endian byte-to-word assembler: four accepted bytes form one 32-bit word,
// first byte landing in bits 7:0.
module word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // r_word only changes when a word completes, so it holds the last assembled word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift <= 24'h0;
      r_cnt   <= 2'd0;
      r_word  <= 32'h0;
    end else if (clr_i) begin
      r_shift <= 24'h0;
      r_cnt   <= 2'd0;
    end else if (take_i) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {byte_i, r_shift[23:8]};
      if (r_cnt == 2'd3) begin
        r_word <= {byte_i, r_shift};
      end
    end
  end

  assign word_o = r_word;
  assign full_o = take_i && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: combinational CPU fetch path in IDLE, byte-wise
// program loader that writes whole words into the memory otherwise.
//
// state   | meaning
// IDLE    | fetch path live, waiting for a load request
// LOAD    | accepting loader bytes into the packer
// WRITE   | one-cycle write of the assembled word
// DONE    | one-cycle completion pulse, back to IDLE
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int AW    = imem_ctrl_pkg::AW,
  parameter int DEPTH = imem_ctrl_pkg::DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ld_start_i,
  input  logic [AW:0]   ld_len_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_byte_i,
  output logic          ld_ready_o,
  input  logic [AW-1:0] fetch_addr_i,
  output logic [31:0]   fetch_inst_o,
  output logic          fetch_valid_o,
  output logic          stall_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          done_o,
  output logic          err_o
);

  logic [1:0]  r_state;
  logic [AW:0] r_len;
  logic [AW:0] r_wcnt;
  logic        r_err;

  logic        w_idle;
  logic        w_len_ok;
  logic        w_start_ok;
  logic        w_take;
  logic        w_full;
  logic [31:0] w_word;
  logic [AW:0] w_wcnt_nxt;

  assign w_idle     = (r_state == S_IDLE);
  assign w_len_ok   = (ld_len_i != '0) && (ld_len_i <= (AW+1)'(DEPTH));
  assign w_start_ok = w_idle && ld_start_i && w_len_ok;
  assign w_take     = (r_state == S_LOAD) && ld_valid_i;
  assign w_wcnt_nxt = r_wcnt + {{AW{1'b0}}, 1'b1};

  word_packer u_packer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_start_ok),
    .take_i (w_take),
    .byte_i (ld_byte_i),
    .word_o (w_word),
    .full_o (w_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_idle && ld_start_i && !w_len_ok;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_len   <= ld_len_i;
            r_wcnt  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_full) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_wcnt  <= w_wcnt_nxt;
          r_state <= (w_wcnt_nxt == r_len) ? S_DONE : S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready_o    = (r_state == S_LOAD);
  assign stall_o       = !w_idle;
  assign fetch_valid_o = w_idle;
  assign fetch_inst_o  = w_idle ? mem_rdata_i : NOP;
  assign mem_we_o      = (r_state == S_WRITE);
  assign mem_addr_o    = mem_we_o ? r_wcnt[AW-1:0] : fetch_addr_i;
  assign mem_wdata_o   = w_word;
  assign done_o        = (r_state == S_DONE);
  assign err_o         = r_err;

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter AW, default 6, instruction-memory address width.
REQ-002 Parameter DEPTH, default 64, instruction-memory depth in words (2**AW).
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 ld_start_i  input  1  request to start a program load; sampled only in IDLE.
REQ-006 ld_len_i  input  AW+1  number of words to load; sampled with ld_start_i.
REQ-007 ld_valid_i  input  1  loader byte valid.
REQ-008 ld_byte_i  input  8  loader data byte.
REQ-009 ld_ready_o  output  1  controller accepts a byte this cycle.
REQ-010 fetch_addr_i  input  AW  CPU fetch word address.
REQ-011 fetch_inst_o  output  32  instruction returned to the CPU.
REQ-012 fetch_valid_o  output  1  fetch_inst_o is valid.
REQ-013 stall_o  output  1  CPU must hold its PC.
REQ-014 mem_addr_o  output  AW  instruction-memory address.
REQ-015 mem_we_o  output  1  instruction-memory write enable.
REQ-016 mem_wdata_o  output  32  instruction-memory write data.
REQ-017 mem_rdata_i  input  32  instruction-memory combinational read data.
REQ-018 done_o  output  1  one-cycle pulse when a load completes.
REQ-019 err_o  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, WRITE and DONE.
REQ-021 In IDLE: mem_addr_o=fetch_addr_i, fetch_inst_o=mem_rdata_i, fetch_valid_o=1, stall_o=0, ld_ready_o=0, mem_we_o=0; fetch path is combinational with zero added latency.
REQ-022 In every state other than IDLE: stall_o=1, fetch_valid_o=0, fetch_inst_o=32'h0000_0000.
REQ-023 In IDLE, ld_start_i=1 with 1<=ld_len_i<=DEPTH SHALL latch ld_len_i, clear the word and byte counters, and move to LOAD.
REQ-024 In IDLE, ld_start_i=1 with ld_len_i=0 or ld_len_i>DEPTH SHALL pulse err_o for one cycle, leaving the FSM in IDLE.
REQ-025 In LOAD: ld_ready_o=1; a byte is accepted when ld_valid_i=1 and ld_ready_o=1.
REQ-026 Accepted bytes SHALL be packed little-endian: byte 0 to bits 7:0, through byte 3 to bits 31:24.
REQ-027 The byte counter (2 bits) SHALL wrap 3->0 on the fourth accepted byte, and the FSM SHALL move to WRITE.
REQ-028 In WRITE (exactly one cycle): mem_we_o=1, mem_addr_o=word counter, mem_wdata_o=assembled word, ld_ready_o=0.
REQ-029 After WRITE the word counter SHALL increment; if it equals the latched length the FSM SHALL go to DONE, otherwise back to LOAD.
REQ-030 DONE SHALL last one cycle with done_o=1 and then return to IDLE; fetch resumes the following cycle.
REQ-031 ld_start_i outside IDLE SHALL be ignored and SHALL NOT pulse err_o.
REQ-032 ld_valid_i in IDLE, WRITE or DONE SHALL be ignored; bytes are never lost, because ld_ready_o=0 there.
REQ-033 Outside WRITE: mem_we_o=0, and mem_wdata_o SHALL hold the last assembled word.
REQ-034 Words are written at addresses 0..len-1 in order; addresses >= len are untouched.

Reset
REQ-035 rst_i=1 at a clock edge SHALL force IDLE, clear the counters, the latched length and the assembly register, and drive done_o=0, err_o=0, mem_we_o=0, ld_ready_o=0, stall_o=0.
REQ-036 Reset mid-load SHALL abandon the load: words already written remain in memory, and the partial word is discarded.
REQ-037 rst_i SHALL take priority over ld_start_i in the same cycle.

Structure
REQ-038 A shared package SHALL hold the state encoding (IDLE, LOAD, WRITE, DONE), AW, DEPTH and the NOP constant 32'h0000_0000.
REQ-039 Byte assembly (shift register plus 2-bit counter) SHALL be a sub-module named word_packer; the FSM and the fetch mux stay in imem_ctrl.

Verification
REQ-040 Reset, then fetch_addr_i=5 with mem_rdata_i=32'hDEADBEEF -> same cycle fetch_inst_o=32'hDEADBEEF, fetch_valid_o=1, stall_o=0.
REQ-041 Start with len=2, bytes 01 02 03 04 05 06 07 08 back-to-back -> writes 32'h04030201@0 and 32'h08070605@1; done_o pulses once; stall_o is high from the cycle after start through DONE.
REQ-042 Start with len=0, and separately len=65 -> err_o pulses once each, stall_o stays 0, no write occurs.
REQ-043 len=1 with ld_valid_i toggled on and off between bytes -> exactly one write, 32'h(b3b2b1b0)@0; no byte is duplicated or dropped.
REQ-044 len=64 full load -> the last write is at address 63, the word counter ends at 64, then DONE and IDLE follow.
REQ-045 len=3, rst_i asserted after the 6th byte -> IDLE next cycle, word@0 written, no write to address 1, done_o never pulses.
